// File: rtl/serializer_shift.sv
// Parallel-in, serial-out shift stage: accepts WIDTH-bit words over valid/ready
// and emits them MSB-first, one bit per cycle, over a second valid/ready pair.

module mux2_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);
  assign y_o = sel_i ? a_i : b_i;
endmodule

module serializer_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Load_valid,
  output logic             Load_ready,
  output logic             Serial_out,
  output logic             Serial_valid,
  output logic             Serial_last,
  input  logic             Serial_ready
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, inner;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             load_hs, bit_xfer;

  assign bit_xfer   = (state_q == ST_SHIFT) & Serial_ready;
  assign Load_ready = nReset & ((state_q == ST_IDLE) | (last_q & Serial_ready));
  assign load_hs    = Load_valid & Load_ready;

  // Two mux levels per bit: shift vs. hold, then load vs. that result.
  // Shifting zeros in means the register is already clear after the last bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    logic shift_src;
    if (i == 0) begin : g_lsb
      assign shift_src = 1'b0;
    end else begin : g_upper
      assign shift_src = sr_q[i-1];
    end
    mux2_cell u_inner (
      .a_i  (shift_src),
      .b_i  (sr_q[i]),
      .sel_i(bit_xfer),
      .y_o  (inner[i])
    );
    mux2_cell u_outer (
      .a_i  (Data_in[i]),
      .b_i  (inner[i]),
      .sel_i(load_hs),
      .y_o  (sr_d[i])
    );
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state for control; a reload at the last bit wins over going idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_hs) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (load_hs) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          last_d  = 1'b0;
        end else if (bit_xfer) begin
          if (last_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            last_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            last_d = (cnt_q == CW'(WIDTH - 2));
          end
        end
      end
    endcase
  end

  assign Serial_out   = sr_q[WIDTH-1];
  assign Serial_valid = (state_q == ST_SHIFT);
  assign Serial_last  = last_q;

endmodule

// File: tb/tb_serializer_shift.sv
// Bench for serializer_shift: directed scenarios plus random traffic, checked
// against a queue-of-bits reference model; a second WIDTH=2 instance covers the boundary.

module tb_serializer_shift;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       lv = 1'b0;
  logic       sready = 1'b0;
  logic       lready, sout, svalid, slast;

  logic [1:0] din2 = '0;
  logic       lv2 = 1'b0;
  logic       sready2 = 1'b0;
  logic       lready2, sout2, svalid2, slast2;

  int total = 0;
  int bad = 0;
  bit exp_q[$];
  logic obs_valid;

  always #5 clk = ~clk;

  serializer_shift #(.WIDTH(8)) dut (
    .Clock(clk), .nReset(rst_n), .Data_in(din), .Load_valid(lv),
    .Load_ready(lready), .Serial_out(sout), .Serial_valid(svalid),
    .Serial_last(slast), .Serial_ready(sready)
  );

  serializer_shift #(.WIDTH(2)) dut2 (
    .Clock(clk), .nReset(rst_n), .Data_in(din2), .Load_valid(lv2),
    .Load_ready(lready2), .Serial_out(sout2), .Serial_valid(svalid2),
    .Serial_last(slast2), .Serial_ready(sready2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check settled outputs against the model,
  // then advance the model by what the coming rising edge will do.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic e_valid, e_out, e_last, e_ready;
    @(negedge clk);
    lv = v; din = d; sready = r;
    #1;
    e_valid = rst_n && (exp_q.size() > 0);
    e_out   = e_valid ? exp_q[0] : 1'b0;
    e_last  = e_valid && (exp_q.size() == 1);
    e_ready = rst_n && ((exp_q.size() == 0) || (exp_q.size() == 1 && r));
    chk("valid", 32'(svalid), 32'(e_valid));
    chk("out",   32'(sout),   32'(e_out));
    chk("last",  32'(slast),  32'(e_last));
    chk("ready", 32'(lready), 32'(e_ready));
    obs_valid = svalid;
    if (!rst_n) exp_q.delete();
    else begin
      if (e_valid && r) void'(exp_q.pop_front());
      if (v && e_ready)
        for (int b = 7; b >= 0; b--) exp_q.push_back(d[b]);
    end
  endtask

  initial begin
    int span;
    // Reset state, before any clock edge.
    #2;
    chk("rst_valid", 32'(svalid), 32'd0);
    chk("rst_out",   32'(sout),   32'd0);
    chk("rst_last",  32'(slast),  32'd0);
    chk("rst_ready", 32'(lready), 32'd0);
    chk("rst_ready2", 32'(lready2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_ready", 32'(lready), 32'd1);

    // Single word A5.
    step(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

    // Back-to-back FF then 00.
    step(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

    // Stall at bit 2 of 81 for three cycles; valid span must be 11.
    step(1'b1, 8'h81, 1'b1);
    span = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h00, !(i >= 2 && i <= 4));
      if (obs_valid) span++;
    end
    chk("stall_span", 32'(span), 32'd11);

    // Busy ignore: 3C offered throughout C3.
    step(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

    // Async reset between edges at bit 4.
    step(1'b1, 8'hB6, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(svalid), 32'd0);
    chk("arst_out",   32'(sout),   32'd0);
    chk("arst_last",  32'(slast),  32'd0);
    chk("arst_ready", 32'(lready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);

    // WIDTH=2 boundary: 2'b10.
    @(negedge clk);
    lv2 = 1'b1; din2 = 2'b10; sready2 = 1'b1;
    #1;
    chk("w2_ready0", 32'(lready2), 32'd1);
    @(negedge clk);
    lv2 = 1'b0;
    #1;
    chk("w2_valid1", 32'(svalid2), 32'd1);
    chk("w2_out1",   32'(sout2),   32'd1);
    chk("w2_last1",  32'(slast2),  32'd0);
    @(negedge clk);
    #1;
    chk("w2_valid2", 32'(svalid2), 32'd1);
    chk("w2_out2",   32'(sout2),   32'd0);
    chk("w2_last2",  32'(slast2),  32'd1);
    @(negedge clk);
    #1;
    chk("w2_valid3", 32'(svalid2), 32'd0);
    chk("w2_ready3", 32'(lready2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
